// File: rtl/fft8_pkg.sv
// Shared constants, FSM state type and Hann coefficients for the 8-point
// FFT frame buffer.
package fft8_pkg;
  localparam int N_PTS = 8;
  localparam int IDX_W = 3;

  typedef enum logic {FILL, RESYNC} state_t;

  // Q13 Hann window, 0x2000 = 1.0
  localparam logic [15:0] HANN_Q13 [N_PTS] = '{
    16'd0, 16'd1199, 16'd4096, 16'd6993, 16'd8192, 16'd6993, 16'd4096, 16'd1199
  };

  function automatic logic signed [15:0] hann_coef(input logic [IDX_W-1:0] idx);
    return HANN_Q13[idx];
  endfunction
endpackage

// File: rtl/fft8_frame_buffer_if.sv
// Serial complex-sample stream (valid/ready) feeding the FFT frame buffer.
interface fft8_frame_buffer_if #(parameter int DW = 24);
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] s_real;
  logic [DW-1:0] s_imag;

  modport master (output s_valid, s_last, s_real, s_imag, input s_ready);
  modport slave  (input s_valid, s_last, s_real, s_imag, output s_ready);
endinterface

// File: rtl/fft8_window_mul.sv
// Registered Hann weighting of one complex sample: (x * w[idx]) >>> 13,
// low DW bits kept (truncation toward -inf).
module fft8_window_mul
  import fft8_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im
);
  localparam int PW = DW + 16;

  logic signed [PW-1:0] coef, p_re, p_im, sh_re, sh_im;

  assign coef  = PW'(hann_coef(idx));
  assign p_re  = PW'($signed(in_re)) * coef;
  assign p_im  = PW'($signed(in_im)) * coef;
  assign sh_re = p_re >>> 13;
  assign sh_im = p_im >>> 13;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      out_re <= '0;
      out_im <= '0;
    end else if (en) begin
      out_re <= sh_re[DW-1:0];
      out_im <= sh_im[DW-1:0];
    end
endmodule

// File: rtl/fft8_frame_buffer.sv
// Assembles a valid/ready complex stream into 8-lane frames using two ping-pong
// banks, rate-limits fft_en and drops malformed frames. Optional Hann window
// on the write path: define FFT8_FRAME_BUFFER_WINDOW_EN.
module fft8_frame_buffer
  import fft8_pkg::*;
#(
  parameter int DW      = 24,
  parameter int MIN_GAP = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  fft8_frame_buffer_if.slave       s,
  output logic                     fft_en,
  output logic [N_PTS-1:0][DW-1:0] x_real,
  output logic [N_PTS-1:0][DW-1:0] x_imag,
  output logic                     frm_err,
  output logic [15:0]              drop_cnt
);
  localparam int               GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LD = (MIN_GAP > 1) ? GAP_W'(MIN_GAP - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic             fill_bank, rd_bank;
  logic [1:0]       full, pend, full_set, full_nxt;
  logic [GAP_W-1:0] gap;
  logic             acc, fill_wr, done, drop, drain;

  logic             wp_vld, wp_done, wp_bank;
  logic [IDX_W-1:0] wp_idx;
  logic [DW-1:0]    wp_re, wp_im;

  logic [1:0][N_PTS-1:0][DW-1:0] mem_re, mem_im;
  logic [N_PTS-1:0][DW-1:0]      x_re_nxt, x_im_nxt;
  logic [N_PTS-1:0]              fwd;

  // pend covers a completed frame still in the window stage, so the fill
  // pointer never lands on a bank that is about to become full.
  assign s.s_ready = !((full[0] | pend[0]) && (full[1] | pend[1]));
  assign acc       = s.s_valid && s.s_ready;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= FILL;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (acc && wr_idx == LAST_IDX && !s.s_last) state_nxt = RESYNC;
      RESYNC:  if (acc && s.s_last) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    fill_wr = acc && (state == FILL);
    done    = fill_wr && s.s_last && (wr_idx == LAST_IDX);
    drop    = fill_wr && (s.s_last != (wr_idx == LAST_IDX));
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_idx    <= '0;
      fill_bank <= 1'b0;
      frm_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      frm_err <= drop;
      if (fill_wr) wr_idx <= (done || drop) ? '0 : wr_idx + 1'b1;
      if (done) fill_bank <= ~fill_bank;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

`ifdef FFT8_FRAME_BUFFER_WINDOW_EN
  logic             w_vld, w_done, w_bank;
  logic [IDX_W-1:0] w_idx;

  fft8_window_mul #(.DW(DW)) u_win (
    .clk    (clk),
    .rstn   (rstn),
    .en     (fill_wr),
    .idx    (wr_idx),
    .in_re  (s.s_real),
    .in_im  (s.s_imag),
    .out_re (wp_re),
    .out_im (wp_im)
  );

  // Framing was decided on the live sample; only the write is delayed.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w_vld  <= 1'b0;
      w_done <= 1'b0;
      w_bank <= 1'b0;
      w_idx  <= '0;
    end else begin
      w_vld  <= fill_wr;
      w_done <= done;
      w_bank <= fill_bank;
      w_idx  <= wr_idx;
    end

  assign wp_vld  = w_vld;
  assign wp_done = w_done;
  assign wp_bank = w_bank;
  assign wp_idx  = w_idx;
  assign pend    = {w_done && w_bank, w_done && !w_bank};
`else
  assign wp_vld  = fill_wr;
  assign wp_done = done;
  assign wp_bank = fill_bank;
  assign wp_idx  = wr_idx;
  assign wp_re   = s.s_real;
  assign wp_im   = s.s_imag;
  assign pend    = 2'b00;
`endif

  always_ff @(posedge clk)
    if (wp_vld) begin
      mem_re[wp_bank][wp_idx] <= wp_re;
      mem_im[wp_bank][wp_idx] <= wp_im;
    end

  // A frame may drain in the cycle its last sample is written, so that
  // sample is forwarded around the bank into the output register.
  for (genvar i = 0; i < N_PTS; i++) begin : g_lane
    assign fwd[i]      = wp_vld && (wp_bank == rd_bank) && (wp_idx == IDX_W'(i));
    assign x_re_nxt[i] = fwd[i] ? wp_re : mem_re[rd_bank][i];
    assign x_im_nxt[i] = fwd[i] ? wp_im : mem_im[rd_bank][i];
  end

  // Banks complete in fill order, so rd_bank always names the oldest one.
  assign full_set = wp_done ? (2'b01 << wp_bank) : 2'b00;
  assign full_nxt = full | full_set;
  assign drain    = full_nxt[rd_bank] && (gap == '0);

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
      gap     <= '0;
      fft_en  <= 1'b0;
      x_real  <= '0;
      x_imag  <= '0;
    end else begin
      fft_en <= drain;
      if (drain) begin
        full    <= full_nxt & ~(2'b01 << rd_bank);
        rd_bank <= ~rd_bank;
        gap     <= GAP_LD;
        x_real  <= x_re_nxt;
        x_imag  <= x_im_nxt;
      end else begin
        full <= full_nxt;
        if (gap != '0) gap <= gap - 1'b1;
      end
    end
endmodule

// File: tb/tb_fft8_frame_buffer.sv
// Self-checking bench for fft8_frame_buffer: directed framing scenarios plus
// randomized traffic against a frame-level reference model.
module tb_fft8_frame_buffer;
  import fft8_pkg::*;

  localparam int DW      = 24;
  localparam int MIN_GAP = 16;
`ifdef FFT8_FRAME_BUFFER_WINDOW_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int SPACING = (MIN_GAP > 8) ? MIN_GAP : 8;

  typedef logic [N_PTS-1:0][DW-1:0] lanes_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fft_en, frm_err;
  lanes_t      x_real, x_imag;
  logic [15:0] drop_cnt;

  fft8_frame_buffer_if #(.DW(DW)) s_if ();

  fft8_frame_buffer #(.DW(DW), .MIN_GAP(MIN_GAP)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s        (s_if),
    .fft_en   (fft_en),
    .x_real   (x_real),
    .x_imag   (x_imag),
    .frm_err  (frm_err),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int err_seen = 0, rdy_low = 0;
  lanes_t got_re[$], got_im[$], exp_re[$], exp_im[$];
  int     got_cyc[$];

  // reference model state
  lanes_t cur_re, cur_im;
  int     cur_n = 0, exp_drops = 0;
  bit     resync = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rstn) begin
      if (fft_en) begin
        got_re.push_back(x_real);
        got_im.push_back(x_imag);
        got_cyc.push_back(cyc);
      end
      if (frm_err) err_seen++;
      if (!s_if.s_ready) rdy_low++;
    end

`ifdef FFT8_FRAME_BUFFER_WINDOW_EN
  function automatic logic [DW-1:0] win(input logic [DW-1:0] v, input int i);
    longint p;
    p = longint'($signed(v)) * longint'(HANN_Q13[i]);
    p = p >>> 13;
    return p[DW-1:0];
  endfunction
`endif

  function automatic void model_accept(input logic [DW-1:0] re, im, input bit last);
    if (resync) begin
      if (last) resync = 0;
      return;
    end
`ifdef FFT8_FRAME_BUFFER_WINDOW_EN
    cur_re[cur_n] = win(re, cur_n);
    cur_im[cur_n] = win(im, cur_n);
`else
    cur_re[cur_n] = re;
    cur_im[cur_n] = im;
`endif
    cur_n++;
    if (last) begin
      if (cur_n == N_PTS) begin
        exp_re.push_back(cur_re);
        exp_im.push_back(cur_im);
      end else exp_drops++;
      cur_n = 0;
    end else if (cur_n == N_PTS) begin
      exp_drops++;
      cur_n  = 0;
      resync = 1;
    end
  endfunction

  function automatic void clear_model();
    got_re.delete(); got_im.delete(); got_cyc.delete();
    exp_re.delete(); exp_im.delete();
    cur_n = 0; exp_drops = 0; resync = 0;
    err_seen = 0; rdy_low = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #1 rstn = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [DW-1:0] re, im, input bit last, output int t);
    int n;
    n = 0;
    s_if.s_valid = 1'b1;
    s_if.s_real  = re;
    s_if.s_imag  = im;
    s_if.s_last  = last;
    while (!s_if.s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_chk++;
      $display("FAIL send_timeout: s_ready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    model_accept(re, im, last);
    @(negedge clk);
    t = cyc;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (got_re.size() < exp_re.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 2000) $display("FAIL drain_timeout: got %0d frames, required %0d", got_re.size(), exp_re.size());
    else n_pass++;
    repeat (MIN_GAP + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (fft_en !== 1'b0) $display("FAIL rst_fft_en: got %b, required 0", fft_en); else n_pass++;
    n_chk++; if (x_real !== '0 || x_imag !== '0) $display("FAIL rst_x: got re=%h im=%h, required 0", x_real, x_imag); else n_pass++;
    n_chk++; if (frm_err !== 1'b0) $display("FAIL rst_frm_err: got %b, required 0", frm_err); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt: got %0d, required 0", drop_cnt); else n_pass++;
    n_chk++; if (s_if.s_ready !== 1'b1) $display("FAIL rst_s_ready: got %b, required 1", s_if.s_ready); else n_pass++;
  endtask

  task automatic test_single_frame();
    int t;
    do_reset();
    for (int n = 0; n < N_PTS; n++) send(DW'(n + 1), DW'(-(n + 1)), n == N_PTS - 1, t);
    wait_drain();
    n_chk++; if (got_re.size() != 1) $display("FAIL sf_count: got %0d pulses, required 1", got_re.size()); else n_pass++;
    if (got_re.size() > 0) begin
      n_chk++; if (got_cyc[0] != t + LAT - 1) $display("FAIL sf_latency: got cycle %0d, required %0d", got_cyc[0], t + LAT - 1); else n_pass++;
      n_chk++;
      if (got_re[0] !== exp_re[0] || got_im[0] !== exp_im[0])
        $display("FAIL sf_data: got re=%h im=%h, required re=%h im=%h", got_re[0], got_im[0], exp_re[0], exp_im[0]);
      else n_pass++;
    end
    n_chk++; if (rdy_low != 0) $display("FAIL sf_s_ready: low for %0d cycles, required 0", rdy_low); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t, t0;
    t0 = 0;
    do_reset();
    for (int f = 0; f < 5; f++)
      for (int i = 0; i < N_PTS; i++) begin
        send(DW'($urandom), DW'($urandom), i == N_PTS - 1, t);
        if (f == 0 && i == N_PTS - 1) t0 = t;
      end
    wait_drain();
    n_chk++; if (got_re.size() != 5) $display("FAIL b2b_count: got %0d frames, required 5", got_re.size()); else n_pass++;
    for (int i = 0; i < got_re.size() && i < exp_re.size(); i++) begin
      n_chk++;
      if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i])
        $display("FAIL b2b_data%0d: got re=%h im=%h, required re=%h im=%h", i, got_re[i], got_im[i], exp_re[i], exp_im[i]);
      else n_pass++;
    end
    if (got_cyc.size() > 0) begin
      n_chk++; if (got_cyc[0] != t0 + LAT - 1) $display("FAIL b2b_latency: got cycle %0d, required %0d", got_cyc[0], t0 + LAT - 1); else n_pass++;
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_chk++;
      if (got_cyc[i] - got_cyc[i-1] != SPACING)
        $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, got_cyc[i] - got_cyc[i-1], SPACING);
      else n_pass++;
    end
    n_chk++; if (rdy_low == 0) $display("FAIL b2b_backpressure: s_ready low for 0 cycles, required >0"); else n_pass++;
  endtask

  task automatic test_short_frame();
    int t;
    do_reset();
    for (int i = 0; i < 5; i++) send(DW'($urandom), DW'($urandom), i == 4, t);
    for (int i = 0; i < N_PTS; i++) send(DW'($urandom), DW'($urandom), i == N_PTS - 1, t);
    wait_drain();
    n_chk++; if (err_seen != 1) $display("FAIL short_frm_err: got %0d pulses, required 1", err_seen); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd1) $display("FAIL short_drop_cnt: got %0d, required 1", drop_cnt); else n_pass++;
    n_chk++; if (got_re.size() != 1) $display("FAIL short_count: got %0d frames, required 1", got_re.size()); else n_pass++;
    if (got_re.size() > 0) begin
      n_chk++;
      if (got_re[0] !== exp_re[0] || got_im[0] !== exp_im[0])
        $display("FAIL short_data: got re=%h im=%h, required re=%h im=%h", got_re[0], got_im[0], exp_re[0], exp_im[0]);
      else n_pass++;
    end
  endtask

  task automatic test_long_frame();
    int t;
    do_reset();
    for (int i = 0; i < N_PTS; i++) send(DW'($urandom), DW'($urandom), 1'b0, t);
    for (int i = 0; i < 3; i++) send(DW'($urandom), DW'($urandom), i == 2, t);
    for (int i = 0; i < N_PTS; i++) send(DW'($urandom), DW'($urandom), i == N_PTS - 1, t);
    wait_drain();
    n_chk++; if (err_seen != 1) $display("FAIL long_frm_err: got %0d pulses, required 1", err_seen); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd1) $display("FAIL long_drop_cnt: got %0d, required 1", drop_cnt); else n_pass++;
    n_chk++; if (rdy_low != 0) $display("FAIL long_s_ready: low for %0d cycles, required 0", rdy_low); else n_pass++;
    n_chk++; if (got_re.size() != 1) $display("FAIL long_count: got %0d frames, required 1", got_re.size()); else n_pass++;
    if (got_re.size() > 0) begin
      n_chk++;
      if (got_re[0] !== exp_re[0] || got_im[0] !== exp_im[0])
        $display("FAIL long_data: got re=%h im=%h, required re=%h im=%h", got_re[0], got_im[0], exp_re[0], exp_im[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    do_reset();
    for (int i = 0; i < 2; i++) send(DW'($urandom), DW'($urandom), i == 1, t);
    for (int i = 0; i < N_PTS; i++) send(DW'($urandom | 1), DW'($urandom), i == N_PTS - 1, t);
    wait_drain();
    for (int i = 0; i < 4; i++) send(DW'($urandom), DW'($urandom), 1'b0, t);
    #1 rstn = 1'b0;
    #1;
    n_chk++; if (x_real !== '0 || x_imag !== '0) $display("FAIL mid_rst_x: got re=%h im=%h, required 0", x_real, x_imag); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0 || frm_err !== 1'b0 || fft_en !== 1'b0)
      $display("FAIL mid_rst_flags: got drop_cnt=%0d frm_err=%b fft_en=%b, required 0", drop_cnt, frm_err, fft_en);
    else n_pass++;
    clear_model();
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    for (int n = 0; n < N_PTS; n++) send(DW'(n + 1), DW'(-(n + 1)), n == N_PTS - 1, t);
    wait_drain();
    n_chk++; if (got_re.size() != 1) $display("FAIL mid_count: got %0d frames, required 1", got_re.size()); else n_pass++;
    if (got_re.size() > 0) begin
      n_chk++;
      if (got_re[0] !== exp_re[0] || got_im[0] !== exp_im[0])
        $display("FAIL mid_data: got re=%h im=%h, required re=%h im=%h", got_re[0], got_im[0], exp_re[0], exp_im[0]);
      else n_pass++;
    end
  endtask

`ifdef FFT8_FRAME_BUFFER_WINDOW_EN
  task automatic test_window();
    int t;
    int hann_exp [N_PTS] = '{0, 1199, 4096, 6993, 8192, 6993, 4096, 1199};
    do_reset();
    for (int n = 0; n < N_PTS; n++) send(24'h002000, 24'hFFE000, n == N_PTS - 1, t);
    wait_drain();
    n_chk++; if (got_re.size() != 1) $display("FAIL win_count: got %0d frames, required 1", got_re.size()); else n_pass++;
    if (got_re.size() > 0) begin
      n_chk++; if (got_cyc[0] != t + 1) $display("FAIL win_latency: got cycle %0d, required %0d", got_cyc[0], t + 1); else n_pass++;
      for (int i = 0; i < N_PTS; i++) begin
        n_chk++;
        if (got_re[0][i] !== DW'(hann_exp[i]) || got_im[0][i] !== DW'(-hann_exp[i]))
          $display("FAIL win_lane%0d: got re=%h im=%h, required re=%h im=%h", i, got_re[0][i], got_im[0][i], DW'(hann_exp[i]), DW'(-hann_exp[i]));
        else n_pass++;
      end
    end
  endtask
`endif

  task automatic test_random();
    int t, kind, len;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 7) begin
        len = $urandom_range(1, N_PTS - 1);
        for (int i = 0; i < len; i++) send(DW'($urandom), DW'($urandom), i == len - 1, t);
      end else if (kind == 8) begin
        for (int i = 0; i < N_PTS; i++) send(DW'($urandom), DW'($urandom), 1'b0, t);
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) send(DW'($urandom), DW'($urandom), i == len - 1, t);
      end else begin
        for (int i = 0; i < N_PTS; i++) begin
          send(DW'($urandom), DW'($urandom), i == N_PTS - 1, t);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
    end
    wait_drain();
    n_chk++; if (got_re.size() != exp_re.size()) $display("FAIL rnd_count: got %0d frames, required %0d", got_re.size(), exp_re.size()); else n_pass++;
    for (int i = 0; i < got_re.size() && i < exp_re.size(); i++) begin
      n_chk++;
      if (got_re[i] !== exp_re[i] || got_im[i] !== exp_im[i])
        $display("FAIL rnd_data%0d: got re=%h im=%h, required re=%h im=%h", i, got_re[i], got_im[i], exp_re[i], exp_im[i]);
      else n_pass++;
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_chk++;
      if (got_cyc[i] - got_cyc[i-1] < MIN_GAP)
        $display("FAIL rnd_gap%0d: got %0d cycles, required >= %0d", i, got_cyc[i] - got_cyc[i-1], MIN_GAP);
      else n_pass++;
    end
    n_chk++; if (err_seen != exp_drops) $display("FAIL rnd_frm_err: got %0d pulses, required %0d", err_seen, exp_drops); else n_pass++;
    n_chk++; if (drop_cnt !== 16'(exp_drops)) $display("FAIL rnd_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); else n_pass++;
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_real  = '0;
    s_if.s_imag  = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
`ifdef FFT8_FRAME_BUFFER_WINDOW_EN
    test_window();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
